ebi_frontend: RTL

EBI_FRONTEND -- requirements
Module: ebi_frontend

---
 rtl/ebi_pkg.sv | 18 +
 rtl/ebi_sync.sv | 50 +++++
 rtl/ebi_frontend.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ebi_pkg.sv
// Shared EBI front-end definitions: FSM state encoding, bus widths and
// address-bank constants used by the back-end decoders.
package ebi_pkg;

    localparam int EBI_ADDR_W = 17;
    localparam int EBI_DATA_W = 16;

    localparam logic [3:0] EBI_BANK_REG  = 4'h0;
    localparam logic [3:0] EBI_BANK_BRAM = 4'h1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ebi_sync.sv
// Multi-flop synchronizer for a bundle of pad inputs, with a falling-edge
// detector on the low EDGE_W bits driven from one extra history flop.
module ebi_sync #(
    parameter int WIDTH  = 20,
    parameter int EDGE_W = 3,
    parameter int STAGES = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  sync,
    output logic [EDGE_W-1:0] fall
);

    genvar gi;

    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] q_reg;
        logic [WIDTH-1:0] d;
        if (gi == 0) begin : g_head
            assign d = din;
        end else begin : g_tail
            assign d = g_stage[gi-1].q_reg;
        end
        always_ff @(posedge clk) begin
            if (srst) begin
                q_reg <= RST_VAL;
            end else begin
                q_reg <= d;
            end
        end
    end

    assign sync = g_stage[STAGES-1].q_reg;

    // History starts at the inactive level so reset release never looks like an edge.
    logic [EDGE_W-1:0] hist_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            hist_reg <= RST_VAL[EDGE_W-1:0];
        end else begin
            hist_reg <= sync[EDGE_W-1:0];
        end
    end

    assign fall = hist_reg & ~sync[EDGE_W-1:0];

endmodule

// File: rtl/ebi_frontend.sv
// EBI slave front end: synchronizes the asynchronous pad bus and turns the
// ALE/nRE/nWE strobe sequence into single-cycle address, read and write pulses.
module ebi_frontend
    import ebi_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_100M,
    input  logic                  rst,
    input  logic [EBI_DATA_W-1:0] ebi_ad_in,
    input  logic                  ebi_ale,
    input  logic                  ebi_ncs,
    input  logic                  ebi_nre,
    input  logic                  ebi_nwe,
    input  logic                  err_clr,
    output logic [EBI_ADDR_W-1:0] addr,
    output logic                  addr_valid,
    output logic                  rd_req,
    output logic                  wr_req,
    output logic [EBI_DATA_W-1:0] wr_data,
    output logic                  rd_active,
    output logic                  selected,
    output logic                  timeout_err,
    output logic                  proto_err
);

    localparam int PAD_W = EBI_DATA_W + 4;
    localparam logic [PAD_W-1:0] PAD_RST = {{EBI_DATA_W{1'b0}}, 4'b1111};
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [PAD_W-1:0] pad_sync;
    logic [2:0]       pad_fall;

    // Data and controls share one chain so ad is aligned with every strobe edge.
    ebi_sync #(
        .WIDTH  (PAD_W),
        .EDGE_W (3),
        .STAGES (SYNC_STAGES),
        .RST_VAL(PAD_RST)
    ) u_sync (
        .clk (clk_100M),
        .srst(rst),
        .din ({ebi_ad_in, ebi_ncs, ebi_nwe, ebi_nre, ebi_ale}),
        .sync(pad_sync),
        .fall(pad_fall)
    );

    logic                  unused_ale_level;
    logic                  ncs_s, nwe_s, nre_s;
    logic [EBI_DATA_W-1:0] ad_s;
    logic                  ale_fall, nre_fall, nwe_fall;

    assign unused_ale_level = pad_sync[0];
    assign nre_s    = pad_sync[1];
    assign nwe_s    = pad_sync[2];
    assign ncs_s    = pad_sync[3];
    assign ad_s     = pad_sync[PAD_W-1:4];
    assign ale_fall = pad_fall[0];
    assign nre_fall = pad_fall[1];
    assign nwe_fall = pad_fall[2];

    state_t                state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [EBI_ADDR_W-1:0] addr_reg;
    logic [EBI_DATA_W-1:0] wr_data_reg;
    logic addr_valid_reg, rd_req_reg, wr_req_reg;
    logic rd_active_reg, selected_reg, timeout_err_reg, proto_err_reg;

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            addr_reg        <= '0;
            wr_data_reg     <= '0;
            addr_valid_reg  <= 1'b0;
            rd_req_reg      <= 1'b0;
            wr_req_reg      <= 1'b0;
            rd_active_reg   <= 1'b0;
            selected_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
            proto_err_reg   <= 1'b0;
        end else begin
            addr_valid_reg <= 1'b0;
            rd_req_reg     <= 1'b0;
            wr_req_reg     <= 1'b0;
            selected_reg   <= ~ncs_s;
            rd_active_reg  <= ~ncs_s & ~nre_s;
            // Clear first so a set later in this block takes priority.
            if (err_clr) begin
                timeout_err_reg <= 1'b0;
                proto_err_reg   <= 1'b0;
            end
            if (ncs_s) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        state_reg <= ADDR;
                        cnt_reg   <= '0;
                    end
                    ADDR: begin
                        if (ale_fall) begin
                            addr_reg       <= {ad_s, 1'b0};
                            addr_valid_reg <= 1'b1;
                            state_reg      <= ACCESS;
                            cnt_reg        <= '0;
                        end else if (cnt_reg >= TMO_LAST) begin
                            timeout_err_reg <= 1'b1;
                            cnt_reg         <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    ACCESS: begin
                        if (nre_fall) begin
                            rd_req_reg <= 1'b1;
                            if (nwe_fall) begin
                                proto_err_reg <= 1'b1;
                            end
                            state_reg <= DONE;
                            cnt_reg   <= '0;
                        end else if (nwe_fall) begin
                            wr_data_reg <= ad_s;
                            wr_req_reg  <= 1'b1;
                            state_reg   <= DONE;
                            cnt_reg     <= '0;
                        end else if (ale_fall) begin
                            addr_reg       <= {ad_s, 1'b0};
                            addr_valid_reg <= 1'b1;
                            cnt_reg        <= (cnt_reg >= TMO_LAST) ? cnt_reg : cnt_reg + CW'(1);
                        end else if (cnt_reg >= TMO_LAST) begin
                            timeout_err_reg <= 1'b1;
                            state_reg       <= ADDR;
                            cnt_reg         <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    DONE: begin
                        if (nre_s && nwe_s) begin
                            state_reg <= ADDR;
                            cnt_reg   <= '0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign addr        = addr_reg;
    assign addr_valid  = addr_valid_reg;
    assign rd_req      = rd_req_reg;
    assign wr_req      = wr_req_reg;
    assign wr_data     = wr_data_reg;
    assign rd_active   = rd_active_reg;
    assign selected    = selected_reg;
    assign timeout_err = timeout_err_reg;
    assign proto_err   = proto_err_reg;

endmodule
